// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants used by the key-scheduling stage and its neighbours.
package rc4_pkg;

   localparam int SBOX_SIZE = 256;
   localparam int SBOX_AW   = 8;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_INIT  = 4'd1,
      S_RD_I  = 4'd2,
      S_CAP_I = 4'd3,
      S_RD_J  = 4'd4,
      S_CAP_J = 4'd5,
      S_WR_I  = 4'd6,
      S_WR_J  = 4'd7,
      S_DONE  = 4'd8
   } ksa_state_t;

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector for a level input.
// Produces a one-cycle pulse that is valid in the same cycle the level first reads high.
module trap_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_level,
   output logic o_rise
);

   logic r_levelPrev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_levelPrev <= 1'b0;
      else       r_levelPrev <= i_level;
   end

   assign o_rise = i_level & ~r_levelPrev;

endmodule

// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling against a single-port 256x8 S-box RAM:
// fill S[i]=i, then 256 read-read-write-write swap iterations.
module ksa_scheduler
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = 32,
   parameter int KEY_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [KEY_LENGTH*KEY_WIDTH-1:0]  key_arr,
   input  logic [7:0]                       q,
   output logic [7:0]                       address,
   output logic [7:0]                       data,
   output logic                             wren,
   output logic                             finished,
   output logic [3:0]                       state_tap
);

   localparam byte_t LAST_I = byte_t'(SBOX_SIZE - 1);
   localparam logic [SBOX_AW-1:0] K_LAST = SBOX_AW'(KEY_LENGTH - 1);

   ksa_state_t         r_state;
   ksa_state_t         w_next;
   byte_t              r_i;
   byte_t              r_j;
   byte_t              r_si;
   byte_t              r_sj;
   logic [SBOX_AW-1:0] r_k;
   byte_t              w_keyByte;
   logic               w_startEdge;

   trap_edge u_startEdge (
      .clk     (clk),
      .reset   (reset),
      .i_level (start),
      .o_rise  (w_startEdge)
   );

   // k is its own wrapping counter, so the key byte is a plain mux rather than i mod KEY_LENGTH.
   always_comb begin
      w_keyByte = '0;
      for (int n = 0; n < KEY_LENGTH; n++) begin
         if (r_k == SBOX_AW'(n)) w_keyByte = key_arr[n*KEY_WIDTH +: KEY_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_si    <= '0;
         r_sj    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_startEdge) begin
                  r_i <= '0;
                  r_j <= '0;
                  r_k <= '0;
               end
            end
            S_INIT: begin
               r_i <= r_i + 8'd1;
               if (r_i == LAST_I) begin
                  r_j <= '0;
                  r_k <= '0;
               end
            end
            S_CAP_I: begin
               r_si <= q;
               r_j  <= r_j + q + w_keyByte;
            end
            S_CAP_J: r_sj <= q;
            S_WR_J: begin
               if (r_i != LAST_I) begin
                  r_i <= r_i + 8'd1;
                  r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // When i==j both writes hit one address and WR_J's si lands last, which is the correct self-swap.
   always_comb begin
      w_next   = r_state;
      address  = '0;
      data     = '0;
      wren     = 1'b0;
      finished = 1'b0;
      case (r_state)
         S_IDLE: if (w_startEdge) w_next = S_INIT;
         S_INIT: begin
            address = r_i;
            data    = r_i;
            wren    = 1'b1;
            if (r_i == LAST_I) w_next = S_RD_I;
         end
         S_RD_I: begin
            address = r_i;
            w_next  = S_CAP_I;
         end
         S_CAP_I: begin
            address = r_i;
            w_next  = S_RD_J;
         end
         S_RD_J: begin
            address = r_j;
            w_next  = S_CAP_J;
         end
         S_CAP_J: begin
            address = r_j;
            w_next  = S_WR_I;
         end
         S_WR_I: begin
            address = r_i;
            data    = r_sj;
            wren    = 1'b1;
            w_next  = S_WR_J;
         end
         S_WR_J: begin
            address = r_j;
            data    = r_si;
            wren    = 1'b1;
            w_next  = (r_i == LAST_I) ? S_DONE : S_RD_I;
         end
         S_DONE: begin
            finished = 1'b1;
            if (w_startEdge) w_next = S_INIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign state_tap = r_state;

endmodule

// File: tb/tb_ksa_scheduler.sv
// Scoreboard bench for ksa_scheduler: expected RAM writes are queued per run and a
// negedge monitor checks every write the DUT issues; two instances cover KEY_LENGTH 3 and 1.
module tb_ksa_scheduler;
   import rc4_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start3, start1;
   logic [23:0] key3;
   logic [7:0]  key1;
   logic [7:0]  q3, q1, addr3, addr1, data3, data1;
   logic        wren3, wren1, fin3, fin1;
   logic [3:0]  tap3, tap1;

   logic [7:0]  mem3 [256];
   logic [7:0]  mem1 [256];
   logic [7:0]  modelS [256];
   logic [15:0] expQ3 [$];
   logic [15:0] expQ1 [$];

   int   compared   = 0;
   int   mismatched = 0;
   int   cycle      = 0;
   bit   strictSb   = 1'b1;
   bit   sel        = 1'b0;

   logic       obsWren, obsFin;
   logic [3:0] obsTap;

   assign obsWren = sel ? wren1 : wren3;
   assign obsFin  = sel ? fin1  : fin3;
   assign obsTap  = sel ? tap1  : tap3;

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   ksa_scheduler #(.KEY_LENGTH(3), .KEY_WIDTH(8)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .start     (start3),
      .key_arr   (key3),
      .q         (q3),
      .address   (addr3),
      .data      (data3),
      .wren      (wren3),
      .finished  (fin3),
      .state_tap (tap3)
   );

   ksa_scheduler #(.KEY_LENGTH(1), .KEY_WIDTH(8)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start1),
      .key_arr   (key1),
      .q         (q1),
      .address   (addr1),
      .data      (data1),
      .wren      (wren1),
      .finished  (fin1),
      .state_tap (tap1)
   );

   // Single-port RAMs: address sampled at the edge, read data valid the following cycle.
   always @(posedge clk) begin
      if (wren3) mem3[addr3] <= data3;
      q3 <= mem3[addr3];
      if (wren1) mem1[addr1] <= data1;
      q1 <= mem1[addr1];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   // Write monitor: every DUT write is checked against the head of its expected queue.
   always @(negedge clk) begin
      logic [15:0] e;
      if (reset !== 1'b1) begin
         if (wren3 === 1'b1) begin
            if (expQ3.size() > 0) begin
               e = expQ3.pop_front();
               checkOutput("dut3 write {addr,data}", {addr3, data3}, e);
            end else if (strictSb) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL dut3 extra write: actual addr=0x%0h data=0x%0h required no write", addr3, data3);
            end
         end
         if (wren1 === 1'b1) begin
            if (expQ1.size() > 0) begin
               e = expQ1.pop_front();
               checkOutput("dut1 write {addr,data}", {addr1, data1}, e);
            end else if (strictSb) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL dut1 extra write: actual addr=0x%0h data=0x%0h required no write", addr1, data1);
            end
         end
      end
   end

   task automatic pushExp(input bit which, input logic [15:0] v);
      if (which) expQ1.push_back(v);
      else       expQ3.push_back(v);
   endtask

   task automatic setStart(input bit which, input logic v);
      if (which) start1 = v;
      else       start3 = v;
   endtask

   // Software KSA: queues the full write stream and leaves the final S-box in modelS.
   task automatic pushModel(input bit which, input int kl, input logic [7:0] kb [3]);
      logic [7:0] s [256];
      logic [7:0] j;
      logic [7:0] t;
      j = 8'h00;
      for (int n = 0; n < 256; n++) begin
         s[n] = n[7:0];
         pushExp(which, {n[7:0], n[7:0]});
      end
      for (int n = 0; n < 256; n++) begin
         j = j + s[n] + kb[n % kl];
         pushExp(which, {n[7:0], s[j]});
         pushExp(which, {j, s[n]});
         t    = s[n];
         s[n] = s[j];
         s[j] = t;
      end
      modelS = s;
   endtask

   task automatic applyStimulus(input bit which, input string tag, input bit midStart,
                                input bit wasDone, input bit checkRam);
      int c0, c1, initLen, diffs;
      bit seen;
      sel = which;
      @(negedge clk);
      setStart(which, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput({tag, " finished before start"}, obsFin, wasDone);
      setStart(which, 1'b1);
      @(negedge clk);
      checkOutput({tag, " INIT on next clock"}, obsWren, 1);
      checkOutput({tag, " finished low after start"}, obsFin, 0);
      seen = obsWren;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = obsWren;
      end
      c0 = cycle;
      initLen = 0;
      while (obsWren && initLen < 300) begin
         initLen++;
         @(negedge clk);
      end
      checkOutput({tag, " consecutive init writes"}, initLen, 256);
      checkOutput({tag, " state after init"}, obsTap, S_RD_I);
      if (midStart) begin
         repeat (200) @(negedge clk);
         setStart(which, 1'b0);
         repeat (3) @(negedge clk);
         setStart(which, 1'b1);
      end
      seen = 1'b0;
      for (int n = 0; n < 2000 && !seen; n++) begin
         @(negedge clk);
         seen = obsFin;
      end
      c1 = cycle;
      checkOutput({tag, " cycles INIT entry to finished"}, c1 - c0, 1792);
      checkOutput({tag, " expected writes outstanding"}, which ? expQ1.size() : expQ3.size(), 0);
      if (checkRam) begin
         diffs = 0;
         for (int n = 0; n < 256; n++) begin
            if ((which ? mem1[n] : mem3[n]) !== modelS[n]) diffs++;
         end
         checkOutput({tag, " RAM bytes differing from model"}, diffs, 0);
      end
      repeat (5) @(negedge clk);
      checkOutput({tag, " finished holds with start high"}, obsFin, 1);
   endtask

   initial begin
      bit seen;
      reset  = 1'b0;
      start3 = 1'b0;
      start1 = 1'b0;
      key3   = '0;
      key1   = '0;

      // Reset asserted between clock edges must clear outputs without an edge.
      #2 reset = 1'b1;
      #1;
      checkOutput("reset address", addr3, 0);
      checkOutput("reset data", data3, 0);
      checkOutput("reset wren", wren3, 0);
      checkOutput("reset finished", fin3, 0);
      checkOutput("reset state", tap3, S_IDLE);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         checkOutput("idle wren", wren3, 0);
         checkOutput("idle finished", fin3, 0);
      end
      checkOutput("idle state", tap3, S_IDLE);

      // First iteration, hand-derived: j=05, S[0]<=05, S[5]<=00, then j=05+01+03=09.
      key3 = {8'hFF, 8'h03, 8'h05};
      strictSb = 1'b0;
      for (int n = 0; n < 256; n++) pushExp(1'b0, {n[7:0], n[7:0]});
      pushExp(1'b0, 16'h0005);
      pushExp(1'b0, 16'h0500);
      pushExp(1'b0, 16'h0109);
      pushExp(1'b0, 16'h0901);
      applyStimulus(1'b0, "first-iter", 1'b0, 1'b0, 1'b0);
      strictSb = 1'b1;

      key3 = {8'hFF, 8'h03, 8'h00};
      pushModel(1'b0, 3, '{8'h00, 8'h03, 8'hFF});
      applyStimulus(1'b0, "full-run", 1'b0, 1'b1, 1'b1);

      pushModel(1'b0, 3, '{8'h00, 8'h03, 8'hFF});
      applyStimulus(1'b0, "mid-start", 1'b1, 1'b1, 1'b1);

      // Abort a run 1000 cycles after INIT entry.
      sel = 1'b0;
      @(negedge clk);
      start3 = 1'b0;
      repeat (2) @(negedge clk);
      pushModel(1'b0, 3, '{8'h00, 8'h03, 8'hFF});
      start3 = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = wren3;
      end
      checkOutput("abort run started", seen, 1);
      repeat (1000) @(negedge clk);
      start3 = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("mid-run reset address", addr3, 0);
      checkOutput("mid-run reset data", data3, 0);
      checkOutput("mid-run reset wren", wren3, 0);
      checkOutput("mid-run reset finished", fin3, 0);
      checkOutput("mid-run reset state", tap3, S_IDLE);
      expQ3.delete();
      @(negedge clk);
      reset = 1'b0;
      pushModel(1'b0, 3, '{8'h00, 8'h03, 8'hFF});
      applyStimulus(1'b0, "after-reset", 1'b0, 1'b0, 1'b1);

      // KEY_LENGTH=1 all-zero key: i==j at i=0 exercises the self-swap.
      key1 = 8'h00;
      pushModel(1'b1, 1, '{8'h00, 8'h00, 8'h00});
      applyStimulus(1'b1, "self-swap", 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ksa_scheduler.md
# ksa_scheduler

RC4 key-scheduling stage. It consumes the packed key array and `finished` flag from the ROM key loader and runs the RC4 KSA against the single-port 256×8 S-box RAM: initialise S[i]=i, then 256 swap iterations. When it finishes, the S-box is ready for the downstream keystream/decrypt stage, which waits on `finished`.

## Interface
- `KEY_LENGTH`, default 32: key bytes in `key_arr`. Legal range is 1..256; it need not be a power of two.
- `KEY_WIDTH`, default 8: bits per key byte. Fixed at 8.
- `clk` input, 1: sole clock; all state changes on its rising edge.
- `reset` input, 1: asynchronous, active-high.
- `start` input, 1: level input. Only its rising edge starts a run.
- `key_arr` input, KEY_LENGTH×8 packed: key bytes. Element 0 is the first RC4 key byte. Must be stable from the start edge until `finished`.
- `q` input, 8: RAM read data.
- `address` output, 8: RAM address.
- `data` output, 8: RAM write data.
- `wren` output, 1: RAM write enable.
- `finished` output, 1: high only in DONE.
- `state_tap` output, 4: current state encoding, for debug.

## Operation
- **Start detection.** Rising edge of `start`, via `trap_edge`. The edge is honoured in IDLE and DONE only; it is ignored in every other state.
- **States (Moore).** Outputs decode from the state register plus the `i`, `j`, `si`, `sj` registers.
  - IDLE: `wren`=0, `address`=0, `data`=0. Goes to INIT on the start edge.
  - INIT: `address`=i, `data`=i, `wren`=1. i increments each cycle. At i=255, set i=0, j=0, k=0 and go to RD_I.
  - RD_I: `address`=i, `wren`=0.
  - CAP_I: latch si=q. Compute j = (j + q + key_arr[k]) mod 256, 8-bit wrap.
  - RD_J: `address`=j.
  - CAP_J: latch sj=q.
  - WR_I: `address`=i, `data`=sj, `wren`=1.
  - WR_J: `address`=j, `data`=si, `wren`=1.
    - If i=255, go to DONE.
    - Otherwise i++, and k = (k==KEY_LENGTH-1) ? 0 : k+1; go to RD_I.
  - DONE: `finished`=1, `wren`=0. Goes to INIT on a new start edge; i, j and k are cleared on that entry.
- **Key index.** k is a separate counter that wraps at KEY_LENGTH-1. No modulo hardware.
- **i==j.** WR_I and WR_J both write the same address. The final value is si, which is the correct self-swap. No special case is needed.
- **RAM contract.** Address and `wren` are sampled at the rising edge. `q` is valid in the following cycle. Write-during-read returns don't-care.
- **Reset.** Asynchronous.
  - State returns to IDLE; i, j, k, si, sj are cleared.
  - Outputs go to `address`=0, `data`=0, `wren`=0, `finished`=0.
  - Reset mid-run leaves RAM contents partial; no recovery is attempted.

## Timing
- From the start edge, INIT is entered on the next clock.
- INIT lasts 256 cycles.
- The swap phase lasts 6 cycles per iteration × 256 iterations = 1536 cycles.
- `finished` rises 1792 cycles after INIT entry and stays high until the next start edge or reset.
- At most one RAM write per cycle. `wren` is high only in INIT, WR_I and WR_J.
- Start edges arriving during INIT through WR_J are dropped; the run is not restarted.
- `start` held high across the end of a run does not retrigger. A fresh rising edge is required.

## Structure
- Shared package `rc4_pkg`:
  - `ksa_state_t` enum, 4-bit.
  - `SBOX_SIZE`=256.
  - `SBOX_AW`=8.
  - byte typedef `byte_t`.
- Sub-module: the existing `trap_edge` for start detection. Everything else is a single flat always_ff/always_comb pair.

## Test plan
- **Reset and idle.** Assert `reset` mid-clock. Outputs go to 0 immediately, without waiting for a clock edge. With no start edge, the block holds IDLE, `wren` stays 0, and `finished` stays 0 for 100 cycles.
- **Init phase.** Give a start edge. Exactly 256 consecutive writes follow with `address`=`data`=0x00..0xFF, then `wren` drops in RD_I.
- **First iteration.** Use KEY_LENGTH=3, key {0x05,0x03,0xFF}, with the RAM model initialised by INIT. Required:
  - first computed j=0x05;
  - WR_I writes S[0]=0x05, WR_J writes S[5]=0x00;
  - second j = 0x05 + 0x01 + 0x03 = 0x09.
- **Full run versus software KSA model.** KEY_LENGTH=3, key {0x00,0x03,0xFF}:
  - `finished` rises exactly 1792 cycles after INIT entry;
  - all 256 RAM bytes match the model;
  - k wraps 0,1,2,0,…
- **Self-swap and wrap.** Use a key chosen so some i==j (all-zero key, KEY_LENGTH=1). Final RAM matches the model. j wraps through 0xFF→0x00 without error.
- **Start and reset during operation.**
  - Start edge during the swap phase: ignored, and the cycle count is unchanged.
  - Reset at cycle 1000 of a run: IDLE with outputs 0; a following start completes a correct run.
  - Start edge in DONE: `finished` drops and a new INIT begins.
